// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// the stall/flush control bundle and the register-address hit helper.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned TMR_W      = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MDU_LAUNCH = 2'd1,
    ST_MDU_WAIT   = 2'd2
  } state_e;

  // Stall/flush controls for PC, IF/ID and ID/EX
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // One source operand of the ID instruction matches the EX destination
  function automatic logic src_hit(input logic                  uses,
                                   input logic [REG_ADDR_W-1:0] rs,
                                   input logic [REG_ADDR_W-1:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational register-dependency compare between the ID sources and the EX
// destination; x0 as a destination never creates a dependency.
// Ports:
//   rs1_addr, rs2_addr  in  source registers of the ID instruction
//   uses_rs1, uses_rs2  in  ID instruction actually reads rs1 / rs2
//   rd_addr             in  destination register of the EX instruction
//   hit_c               out dependency exists (combinational)
module pipe_hazard_ctrl_load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  hit_c
);

  assign hit_c = (rd_addr != '0) &&
                 (src_hit(uses_rs1, rs1_addr, rd_addr) ||
                  src_hit(uses_rs2, rs2_addr, rd_addr));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID and ID/EX pipeline registers.
// Handles load-use bubbles, multi-cycle MDU operations held in EX (with a
// timeout abort) and EX-resolved redirects; counts PC-stall cycles.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   id_*_i                        ID-stage instruction validity and sources
//   ex_*_i                        ID/EX register contents (valid, load, rd, M-op)
//   redirect_i                    taken jump/branch resolved in EX
//   mdu_done_i                    MDU result valid pulse
//   pc_stall_o .. id_ex_flush_o   combinational stall/flush controls
//   mdu_start_o                   registered one-cycle MDU launch pulse
//   mdu_timeout_o                 sticky MDU abort flag
//   stall_cycles_o                saturating count of PC-stall cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_memread_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_m_instr_i,
  input  logic                  redirect_i,
  input  logic                  mdu_done_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_stall_o,
  output logic                  id_ex_flush_o,
  output logic                  mdu_start_o,
  output logic                  mdu_timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  state_e             state_q, state_d;
  pipe_ctrl_t         ctrl_c;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   stall_cycles_q;
  logic               mdu_start_q;
  logic               mdu_timeout_q;
  logic               rd_hit_c;
  logic               load_use_c;
  logic               m_in_ex_c;
  logic               abort_c;

  // Source/destination dependency compare
  pipe_hazard_ctrl_load_use_detect u_load_use_detect (
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .uses_rs1 (id_uses_rs1_i),
    .uses_rs2 (id_uses_rs2_i),
    .rd_addr  (ex_rd_addr_i),
    .hit_c    (rd_hit_c)
  );

  assign load_use_c = ex_valid_i & ex_memread_i & id_valid_i & rd_hit_c;
  assign m_in_ex_c  = ex_valid_i & ex_m_instr_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and stall/flush decode
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    abort_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          ctrl_c.if_id_flush = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end else if (m_in_ex_c) begin
          ctrl_c.pc_stall    = 1'b1;
          ctrl_c.if_id_stall = 1'b1;
          ctrl_c.id_ex_stall = 1'b1;
          state_d            = ST_MDU_LAUNCH;
        end else if (load_use_c) begin
          ctrl_c.pc_stall    = 1'b1;
          ctrl_c.if_id_stall = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
        end
      end
      ST_MDU_LAUNCH, ST_MDU_WAIT: begin
        // An early done in the launch cycle releases the pipe exactly like in MDU_WAIT
        if (mdu_done_i) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_MDU_WAIT) &&
                     (timer_q == TMR_W'(MDU_TIMEOUT - 1))) begin
          // Abort: drop the stuck M instruction, ID waits one more cycle
          ctrl_c.pc_stall    = 1'b1;
          ctrl_c.if_id_stall = 1'b1;
          ctrl_c.id_ex_flush = 1'b1;
          abort_c            = 1'b1;
          state_d            = ST_RUN;
        end else begin
          ctrl_c.pc_stall    = 1'b1;
          ctrl_c.if_id_stall = 1'b1;
          ctrl_c.id_ex_stall = 1'b1;
          state_d            = ST_MDU_WAIT;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Controls are forced quiet while reset is held, whatever the inputs do
    if (!rst_ni) begin
      ctrl_c = '0;
    end
  end

  // Launch pulse, MDU timer, sticky abort flag and perf counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdu_start_q    <= 1'b0;
      timer_q        <= '0;
      mdu_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      mdu_start_q <= (state_d == ST_MDU_LAUNCH);
      if (state_q == ST_MDU_WAIT) begin
        timer_q <= timer_q + TMR_W'(1);
      end else begin
        timer_q <= '0;
      end
      if (abort_c) begin
        mdu_timeout_q <= 1'b1;
      end
      if (ctrl_c.pc_stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end
    end
  end

  assign pc_stall_o     = ctrl_c.pc_stall;
  assign if_id_stall_o  = ctrl_c.if_id_stall;
  assign if_id_flush_o  = ctrl_c.if_id_flush;
  assign id_ex_stall_o  = ctrl_c.id_ex_stall;
  assign id_ex_flush_o  = ctrl_c.id_ex_flush;
  assign mdu_start_o    = mdu_start_q;
  assign mdu_timeout_o  = mdu_timeout_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table for RUN-state decode,
// directed MDU/reset sequences and a randomized run against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TO      = 8;
  localparam int          CNT_MAX = 15;

  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b11001;
  localparam logic [4:0] C_MDU   = 5'b11010;
  localparam logic [4:0] C_REDIR = 5'b00101;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic id_valid = 1'b0, id_u1 = 1'b0, id_u2 = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_valid = 1'b0, ex_memread = 1'b0, ex_m = 1'b0;
  logic redirect = 1'b0, mdu_done = 1'b0;

  logic pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o;
  logic mdu_start_o, mdu_timeout_o;
  logic [CNT_W-1:0] stall_cycles_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  // Reference model: MDU age in cycles since launch (-1 = no MDU op in flight)
  int   m_age = -1;
  int   m_next_age;
  int   m_cnt = 0;
  logic m_to = 1'b0;
  logic m_set_to;
  logic e_pc, e_ifs, e_iff, e_exs, e_exf;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TO)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .id_valid_i     (id_valid),
    .id_rs1_addr_i  (id_rs1),
    .id_rs2_addr_i  (id_rs2),
    .id_uses_rs1_i  (id_u1),
    .id_uses_rs2_i  (id_u2),
    .ex_valid_i     (ex_valid),
    .ex_memread_i   (ex_memread),
    .ex_rd_addr_i   (ex_rd),
    .ex_m_instr_i   (ex_m),
    .redirect_i     (redirect),
    .mdu_done_i     (mdu_done),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_stall_o  (id_ex_stall_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .mdu_start_o    (mdu_start_o),
    .mdu_timeout_o  (mdu_timeout_o),
    .stall_cycles_o (stall_cycles_o)
  );

  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic       mr;
    logic [4:0] rd;
    logic       redir;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected controls for the current inputs, straight from the hazard rules
  task automatic model_eval();
    logic lu;
    lu = ex_valid && ex_memread && (ex_rd != 5'd0) && id_valid &&
         ((id_u1 && (id_rs1 == ex_rd)) || (id_u2 && (id_rs2 == ex_rd)));
    {e_pc, e_ifs, e_iff, e_exs, e_exf} = 5'b0;
    m_next_age = m_age;
    m_set_to   = 1'b0;
    if (m_age < 0) begin
      if (redirect) begin
        e_iff = 1'b1; e_exf = 1'b1;
      end else if (ex_valid && ex_m) begin
        e_pc = 1'b1; e_ifs = 1'b1; e_exs = 1'b1;
        m_next_age = 0;
      end else if (lu) begin
        e_pc = 1'b1; e_ifs = 1'b1; e_exf = 1'b1;
      end
    end else if (mdu_done) begin
      m_next_age = -1;
    end else if (m_age == int'(TO)) begin
      e_pc = 1'b1; e_ifs = 1'b1; e_exf = 1'b1;
      m_next_age = -1;
      m_set_to   = 1'b1;
    end else begin
      e_pc = 1'b1; e_ifs = 1'b1; e_exs = 1'b1;
      m_next_age = m_age + 1;
    end
  endtask

  task automatic model_commit();
    if (e_pc && (m_cnt < CNT_MAX)) m_cnt++;
    if (m_set_to) m_to = 1'b1;
    m_age = m_next_age;
  endtask

  task automatic model_reset();
    m_age = -1;
    m_cnt = 0;
    m_to  = 1'b0;
  endtask

  // One clock cycle: compare on the falling edge, then advance past the rising edge
  task automatic step(input string tag, output logic [4:0] comb);
    logic [10:0] act, exp;
    @(negedge clk_i);
    model_eval();
    comb = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o};
    act  = {comb, mdu_start_o, mdu_timeout_o, stall_cycles_o};
    exp  = {e_pc, e_ifs, e_iff, e_exs, e_exf, (m_age == 0), m_to, CNT_W'(m_cnt)};
    check(tag, 32'(act), 32'(exp));
    check({tag, "/excl"},
          32'((if_id_stall_o & if_id_flush_o) | (id_ex_stall_o & id_ex_flush_o)), 32'd0);
    if (mdu_start_o) n_start++;
    model_commit();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_u1 = 1'b0; id_u2 = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0; ex_m = 1'b0;
    redirect = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2; id_u1 = v.u1; id_u2 = v.u2;
    ex_valid = v.exv; ex_memread = v.mr; ex_rd = v.rd; ex_m = 1'b0;
    redirect = v.redir; mdu_done = 1'b0;
  endtask

  function automatic logic [10:0] all_outs();
    return {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
            mdu_start_o, mdu_timeout_o, stall_cycles_o};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] c;
    int abort_at;

    //             idv  rs1    rs2    u1  u2  exv mr  rd     redir exp
    vecs[0] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, C_IDLE};
    vecs[1] = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, C_LU};
    vecs[2] = '{1'b1, 5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, C_LU};
    vecs[3] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, C_IDLE};
    vecs[4] = '{1'b1, 5'd5,  5'd1,  1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, C_IDLE};
    vecs[5] = '{1'b0, 5'd5,  5'd1,  1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b0, C_IDLE};
    vecs[6] = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 1'b0, 1'b1, 5'd5,  1'b0, C_IDLE};
    vecs[7] = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 1'b1, 1'b0, 5'd5,  1'b0, C_IDLE};
    vecs[8] = '{1'b1, 5'd5,  5'd1,  1'b1, 1'b1, 1'b1, 1'b1, 5'd5,  1'b1, C_REDIR};
    vecs[9] = '{1'b1, 5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, C_LU};

    // Reset: outputs quiet even with a redirect on the inputs
    idle();
    redirect = 1'b1;
    #12;
    check("reset_outs", 32'(all_outs()), 32'd0);
    redirect = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step("post_reset", c);
    check("post_reset_ctl", 32'(c), 32'(C_IDLE));

    // lw x5 in EX, add x6,x5,x1 in ID: one bubble, then the bubble sits in EX
    apply_vec(vecs[1]);
    step("lu_basic", c);
    check("lu_basic_ctl", 32'(c), 32'(C_LU));
    idle();
    id_valid = 1'b1; id_rs1 = 5'd5; id_rs2 = 5'd1; id_u1 = 1'b1; id_u2 = 1'b1;
    step("lu_release", c);
    check("lu_release_ctl", 32'(c), 32'(C_IDLE));
    check("lu_stall_count", 32'(stall_cycles_o), 32'd1);

    // RUN-state decode table
    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i]);
      step($sformatf("vec%0d", i), c);
      check($sformatf("vec%0d_ctl", i), 32'(c), 32'(vecs[i].exp));
    end

    // Perf counter saturates at all-ones
    apply_vec(vecs[1]);
    for (int i = 0; i < 20; i++) step("sat", c);
    check("sat_count", 32'(stall_cycles_o), 32'(CNT_MAX));

    // MDU op completing 5 cycles after the launch pulse
    idle();
    ex_valid = 1'b1; ex_m = 1'b1;
    n_start = 0;
    step("mdu_detect", c);
    check("mdu_detect_ctl", 32'(c), 32'(C_MDU));
    for (int i = 0; i < 5; i++) begin
      step("mdu_busy", c);
      check("mdu_busy_ctl", 32'(c), 32'(C_MDU));
    end
    mdu_done = 1'b1;
    step("mdu_done", c);
    check("mdu_done_ctl", 32'(c), 32'(C_IDLE));
    idle();
    step("mdu_after", c);
    check("mdu_after_ctl", 32'(c), 32'(C_IDLE));
    check("mdu_start_pulses", 32'(n_start), 32'd1);

    // MDU op that never completes: abort 8 cycles after launch
    ex_valid = 1'b1; ex_m = 1'b1;
    step("to_detect", c);
    abort_at = -1;
    for (int i = 0; i < 12; i++) begin
      step("to_wait", c);
      if (c[0]) begin
        abort_at = i;
        check("to_abort_ctl", 32'(c), 32'(C_LU));
        break;
      end
    end
    check("to_abort_cycle", 32'(abort_at), 32'(TO));
    idle();
    step("to_after", c);
    step("to_after2", c);
    check("to_sticky", 32'(mdu_timeout_o), 32'd1);

    // Async reset in the middle of MDU_WAIT, then a late done
    ex_valid = 1'b1; ex_m = 1'b1;
    step("rst_detect", c);
    step("rst_launch", c);
    step("rst_wait1", c);
    step("rst_wait2", c);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_outs", 32'(all_outs()), 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle();
    mdu_done = 1'b1;
    step("late_done", c);
    check("late_done_ctl", 32'(c), 32'(C_IDLE));
    mdu_done = 1'b0;
    step("rst_idle", c);
    check("rst_counter", 32'(stall_cycles_o), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      id_valid   = ($urandom_range(0, 9) < 8);
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_u1      = 1'($urandom_range(0, 1));
      id_u2      = 1'($urandom_range(0, 1));
      ex_valid   = ($urandom_range(0, 9) < 7);
      ex_memread = ($urandom_range(0, 9) < 4);
      ex_rd      = 5'($urandom_range(0, 3));
      ex_m       = ($urandom_range(0, 99) < 15);
      redirect   = ($urandom_range(0, 99) < 10);
      mdu_done   = ($urandom_range(0, 99) < 8);
      step("rand", c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
